lsu_addrcheck_mpu: RTL and testbench
====================================

Name: lsu_addrcheck_mpu

Overview:
Parametrised, pipelined successor to the LSU address checker. Sits between LSU address generation (dc1) and the dc2 pipe register. Classifies each access as DCCM, PIC or external, and flags access and misaligned faults. Adds a runtime-programmable N-entry data-access region table with separate load/store permissions, a valid/ready-decoupled result stage, and a sticky first-fault capture register with a saturating fault counter.

Parameters:
NUM_REGIONS, 8, entries in the data-access region table (1..16)
DCCM_ENABLE, 1, 0 forces all DCCM hits to 0
DCCM_SADR, 32'hF004_0000, DCCM base address
DCCM_SIZE, 64, DCCM size in KB (power of 2)
PIC_SADR, 32'hF00C_0000, PIC base address
PIC_SIZE, 32, PIC size in KB (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  access request
req_ready  out  1  request accepted when req_valid&req_ready
req_addr  in  32  start address
req_size  in  2  0=byte 1=half 2=word (3 illegal, treated as word)
req_store  in  1  1=store 0=load
req_dma  in  1  DMA access; suppresses faults and capture
mrac  in  32  MRAC CSR; bit {addr[31:28],1} = side-effect
cfg_we  in  1  region-table write
cfg_idx  in  $clog2(NUM_REGIONS)  entry index; out-of-range writes ignored
cfg_base  in  32  region base
cfg_mask  in  32  region don't-care mask
cfg_en  in  1  entry enable
cfg_rd  in  1  loads permitted
cfg_wr  in  1  stores permitted
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_in_dccm  out  1  start and end in DCCM
rsp_in_pic  out  1  start and end in PIC
rsp_external  out  1  ~(in_dccm|in_pic)
rsp_sideeffects  out  1  side-effect attribute
rsp_access_fault  out  1  access fault
rsp_misaligned  out  1  misaligned fault
fault_pend  out  1  sticky fault captured
fault_addr  out  32  captured start address
fault_type  out  2  bit0 access, bit1 misaligned
fault_store  out  1  captured op was store
fault_clr  in  1  clear fault_pend
fault_cnt  out  8  saturating count of faulting requests

Behaviour:
- Reset: all rsp_* = 0; fault_pend, fault_addr, fault_type, fault_store, fault_cnt = 0; all table entries cleared (en = rd = wr = 0).
- Handshake: one-entry output register. req_ready = ~rsp_valid | rsp_ready.
- Accepted request: result visible on rsp_* the next cycle.
- rsp_valid and rsp_* hold stable until rsp_ready. Back-to-back acceptance occurs at full throughput.
- End address: end = req_addr + {0,1,3,3}[req_size], modulo 2^32. 0xFFFF_FFFF word wraps to 0x0000_0002.
- DCCM range: [DCCM_SADR, DCCM_SADR+DCCM_SIZE*1024). DCCM region: addr[31:28]==DCCM_SADR[31:28]. PIC is defined the same way.
- Side effects: sideeffects = mrac[{start[31:28],1}] & ~(start in DCCM region | start in PIC region).
- Region match: (a|mask)==(base|mask) & en & (req_store ? wr : rd).
- non_dccm_ok is true in either case:
  - no entry enabled; or
  - start matches some permitted entry and end matches some permitted entry (entries may differ).
- Access fault, if any of the following, gated by ~req_dma:
  - start or end in DCCM/PIC region but outside its range;
  - start and end split between DCCM and PIC;
  - PIC access not word-sized or addr[1:0]!=0;
  - start outside DCCM and PIC regions and ~non_dccm_ok.
- Misaligned fault = (start[31:28]!=end[31:28] | (sideeffects & unaligned)) & external & ~req_dma.
- Table write timing: a table write takes effect the cycle after cfg_we. A request accepted in the same cycle as the write uses the old entry.
- Fault capture, on acceptance of a request with any fault:
  - fault_cnt increments, saturating at 255;
  - if ~fault_pend: latch addr, type and store, and set fault_pend.
  - Later faults do not overwrite a pending capture.
- fault_clr: clears fault_pend the next cycle; captured data holds.
- fault_clr and a new fault in the same cycle: the new fault is captured and fault_pend stays 1.
- Reset mid-transaction: the pending rsp is dropped and the table is cleared.

Test Plan:
- Word load 0xF004_0010, table empty -> next cycle rsp_in_dccm=1, no faults, fault_cnt=0.
- Half load 0xF004_FFFF (DCCM 64KB) -> end 0xF005_0000 outside range, rsp_access_fault=1, fault_addr=0xF004_FFFF, fault_type=01, fault_pend=1.
- Entry0 {base 0x2000_0000, mask 0x0FFF_FFFF, en, rd only}:
  - store 0x2000_0100 -> access fault, fault_store=1;
  - load to the same address -> no fault.
- mrac bit 5 set, word load 0x2000_0002 -> rsp_sideeffects=1, rsp_misaligned=1, fault_type=10. Same access with req_dma=1 -> no faults, fault_cnt unchanged.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_* stable.
  - Release -> next request accepted that cycle, result the cycle after.
- fault_pend=1 with fault_clr and a faulting request in the same cycle -> fault_pend stays 1, fault_addr updates.
  - 300 faults -> fault_cnt=255.

Source files
------------

// File: rtl/lsu_addrcheck_mpu.sv
// LSU address checker with a programmable data-access region table, a one-entry
// valid/ready result register and a sticky first-fault capture with a saturating counter.
module lsu_addrcheck_mpu #(
  parameter int unsigned NUM_REGIONS = 8,
  parameter int unsigned DCCM_ENABLE = 1,
  parameter logic [31:0] DCCM_SADR   = 32'hF004_0000,
  parameter int unsigned DCCM_SIZE   = 64,
  parameter logic [31:0] PIC_SADR    = 32'hF00C_0000,
  parameter int unsigned PIC_SIZE    = 32,
  localparam int unsigned IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_store,
  input  logic              req_dma,
  input  logic [31:0]       mrac,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [31:0]       cfg_base,
  input  logic [31:0]       cfg_mask,
  input  logic              cfg_en,
  input  logic              cfg_rd,
  input  logic              cfg_wr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_in_dccm,
  output logic              rsp_in_pic,
  output logic              rsp_external,
  output logic              rsp_sideeffects,
  output logic              rsp_access_fault,
  output logic              rsp_misaligned,
  output logic              fault_pend,
  output logic [31:0]       fault_addr,
  output logic [1:0]        fault_type,
  output logic              fault_store,
  input  logic              fault_clr,
  output logic [7:0]        fault_cnt
);

  localparam logic        DCCM_EN  = (DCCM_ENABLE != 0);
  localparam logic [32:0] DCCM_LIM = {1'b0, DCCM_SADR} + 33'(DCCM_SIZE) * 33'd1024;
  localparam logic [32:0] PIC_LIM  = {1'b0, PIC_SADR} + 33'(PIC_SIZE) * 33'd1024;

  logic [31:0]            tbl_base [NUM_REGIONS];
  logic [31:0]            tbl_mask [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] tbl_en;
  logic [NUM_REGIONS-1:0] tbl_rd;
  logic [NUM_REGIONS-1:0] tbl_wr;

  logic [31:0] end_addr;
  logic [31:0] size_off;
  logic s_dccm_rgn, e_dccm_rgn, s_pic_rgn, e_pic_rgn;
  logic s_dccm, e_dccm, s_pic, e_pic;
  logic in_dccm, in_pic, external, sideeffects;
  logic start_hit, end_hit, non_dccm_ok;
  logic unaligned, pic_bad, access_fault, misaligned, any_fault;
  logic req_fire;

  function automatic logic in_range(logic [31:0] a, logic [31:0] base, logic [32:0] lim);
    return (a >= base) && ({1'b0, a} < lim);
  endfunction

  assign req_ready = ~rsp_valid | rsp_ready;
  assign req_fire  = req_valid & req_ready;

  // Address classification against DCCM / PIC windows and regions
  always_comb begin
    case (req_size)
      2'd0:    size_off = 32'd0;
      2'd1:    size_off = 32'd1;
      default: size_off = 32'd3;
    endcase
    end_addr   = req_addr + size_off;
    s_dccm_rgn = DCCM_EN & (req_addr[31:28] == DCCM_SADR[31:28]);
    e_dccm_rgn = DCCM_EN & (end_addr[31:28] == DCCM_SADR[31:28]);
    s_dccm     = DCCM_EN & in_range(req_addr, DCCM_SADR, DCCM_LIM);
    e_dccm     = DCCM_EN & in_range(end_addr, DCCM_SADR, DCCM_LIM);
    s_pic_rgn  = (req_addr[31:28] == PIC_SADR[31:28]);
    e_pic_rgn  = (end_addr[31:28] == PIC_SADR[31:28]);
    s_pic      = in_range(req_addr, PIC_SADR, PIC_LIM);
    e_pic      = in_range(end_addr, PIC_SADR, PIC_LIM);
    in_dccm    = s_dccm & e_dccm;
    in_pic     = s_pic & e_pic;
    external   = ~(in_dccm | in_pic);
    sideeffects = mrac[{req_addr[31:28], 1'b1}] & ~(s_dccm_rgn | s_pic_rgn);
  end

  // Region table lookup; start and end may hit different permitted entries
  always_comb begin
    start_hit = 1'b0;
    end_hit   = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (tbl_en[i] && (req_store ? tbl_wr[i] : tbl_rd[i])) begin
        if ((req_addr | tbl_mask[i]) == (tbl_base[i] | tbl_mask[i])) start_hit = 1'b1;
        if ((end_addr | tbl_mask[i]) == (tbl_base[i] | tbl_mask[i])) end_hit = 1'b1;
      end
    end
    non_dccm_ok = ~(|tbl_en) | (start_hit & end_hit);
  end

  always_comb begin
    unaligned = ((req_size == 2'd1) & req_addr[0]) | (req_size[1] & (|req_addr[1:0]));
    pic_bad   = s_pic_rgn & (~req_size[1] | (|req_addr[1:0]));
    access_fault = ~req_dma & (
                     (s_dccm_rgn & ~s_dccm) | (e_dccm_rgn & ~e_dccm) |
                     (s_pic_rgn & ~s_pic)   | (e_pic_rgn & ~e_pic)   |
                     (s_dccm & e_pic) | (s_pic & e_dccm) | pic_bad   |
                     (~s_dccm_rgn & ~s_pic_rgn & ~non_dccm_ok));
    misaligned = ((req_addr[31:28] != end_addr[31:28]) | (sideeffects & unaligned)) &
                 external & ~req_dma;
    any_fault  = access_fault | misaligned;
  end

  // Result register: loads on acceptance, empties when consumed with nothing new
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid        <= 1'b0;
      rsp_in_dccm      <= 1'b0;
      rsp_in_pic       <= 1'b0;
      rsp_external     <= 1'b0;
      rsp_sideeffects  <= 1'b0;
      rsp_access_fault <= 1'b0;
      rsp_misaligned   <= 1'b0;
    end else if (req_fire) begin
      rsp_valid        <= 1'b1;
      rsp_in_dccm      <= in_dccm;
      rsp_in_pic       <= in_pic;
      rsp_external     <= external;
      rsp_sideeffects  <= sideeffects;
      rsp_access_fault <= access_fault;
      rsp_misaligned   <= misaligned;
    end else if (rsp_ready) begin
      rsp_valid        <= 1'b0;
    end
  end

  // First-fault capture; a clear in the same cycle as a new fault lets it overwrite
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_pend  <= 1'b0;
      fault_addr  <= 32'd0;
      fault_type  <= 2'd0;
      fault_store <= 1'b0;
      fault_cnt   <= 8'd0;
    end else begin
      if (req_fire && any_fault && (!fault_pend || fault_clr)) begin
        fault_pend  <= 1'b1;
        fault_addr  <= req_addr;
        fault_type  <= {misaligned, access_fault};
        fault_store <= req_store;
      end else if (fault_clr) begin
        fault_pend  <= 1'b0;
      end
      if (req_fire && any_fault && (fault_cnt != 8'hFF)) fault_cnt <= fault_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        tbl_base[i] <= 32'd0;
        tbl_mask[i] <= 32'd0;
      end
      tbl_en <= '0;
      tbl_rd <= '0;
      tbl_wr <= '0;
    end else if (cfg_we && (32'(cfg_idx) < NUM_REGIONS)) begin
      tbl_base[cfg_idx] <= cfg_base;
      tbl_mask[cfg_idx] <= cfg_mask;
      tbl_en[cfg_idx]   <= cfg_en;
      tbl_rd[cfg_idx]   <= cfg_rd;
      tbl_wr[cfg_idx]   <= cfg_wr;
    end
  end

endmodule

// File: tb/tb_lsu_addrcheck_mpu.sv
// Scoreboard bench for lsu_addrcheck_mpu: arithmetic reference model, directed
// scenarios followed by randomized traffic with back-pressure and table rewrites.
module tb_lsu_addrcheck_mpu;
  localparam int unsigned NR = 8;
  localparam longint DB = 64'hF004_0000;
  localparam longint DL = DB + 64 * 1024;
  localparam longint PB = 64'hF00C_0000;
  localparam longint PL = PB + 32 * 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_store = 1'b0, req_dma = 1'b0;
  logic [31:0] mrac = 32'd0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = 3'd0;
  logic [31:0] cfg_base = 32'd0, cfg_mask = 32'd0;
  logic        cfg_en = 1'b0, cfg_rd = 1'b0, cfg_wr = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic        rsp_in_dccm, rsp_in_pic, rsp_external, rsp_sideeffects;
  logic        rsp_access_fault, rsp_misaligned;
  logic        fault_pend, fault_store, fault_clr = 1'b0;
  logic [31:0] fault_addr;
  logic [1:0]  fault_type;
  logic [7:0]  fault_cnt;

  lsu_addrcheck_mpu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_store(req_store), .req_dma(req_dma),
    .mrac(mrac), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en), .cfg_rd(cfg_rd), .cfg_wr(cfg_wr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_in_dccm(rsp_in_dccm),
    .rsp_in_pic(rsp_in_pic), .rsp_external(rsp_external),
    .rsp_sideeffects(rsp_sideeffects), .rsp_access_fault(rsp_access_fault),
    .rsp_misaligned(rsp_misaligned), .fault_pend(fault_pend), .fault_addr(fault_addr),
    .fault_type(fault_type), .fault_store(fault_store), .fault_clr(fault_clr),
    .fault_cnt(fault_cnt)
  );

  // {in_dccm, in_pic, external, sideeffects, access_fault, misaligned}
  typedef logic [5:0] rsp_t;
  rsp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  bit          m_valid, m_pend, m_fstore;
  logic [31:0] m_faddr;
  logic [1:0]  m_ftype;
  int          m_cnt;
  logic [31:0] m_base [NR];
  logic [31:0] m_mask [NR];
  bit          m_en [NR];
  bit          m_rd [NR];
  bit          m_wr [NR];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_pend = 0; m_fstore = 0; m_faddr = 0; m_ftype = 0; m_cnt = 0;
    for (int i = 0; i < NR; i++) begin
      m_base[i] = 0; m_mask[i] = 0; m_en[i] = 0; m_rd[i] = 0; m_wr[i] = 0;
    end
    exp_q.delete();
  endfunction

  function automatic bit covered(longint x, bit st);
    for (int i = 0; i < NR; i++)
      if (m_en[i] && (st ? m_wr[i] : m_rd[i]) &&
          ((x & ~longint'(m_mask[i])) == (longint'(m_base[i]) & ~longint'(m_mask[i]))))
        return 1;
    return 0;
  endfunction

  function automatic rsp_t ref_model(logic [31:0] a, logic [1:0] sz, bit st, bit dma,
                                     logic [31:0] mr);
    longint s, e, len;
    bit sd_rg, ed_rg, sp_rg, ep_rg, sd, ed, sp, ep, in_d, in_p, ext, se, ok, any, af, mis;
    s   = longint'({32'd0, a});
    len = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    e   = (s + len - 1) % 64'h1_0000_0000;
    sd_rg = (s >> 28) == (DB >> 28);  ed_rg = (e >> 28) == (DB >> 28);
    sp_rg = (s >> 28) == (PB >> 28);  ep_rg = (e >> 28) == (PB >> 28);
    sd = s >= DB && s < DL;  ed = e >= DB && e < DL;
    sp = s >= PB && s < PL;  ep = e >= PB && e < PL;
    in_d = sd && ed;  in_p = sp && ep;  ext = !(in_d || in_p);
    se = mr[int'(2 * (s >> 28) + 1)] && !sd_rg && !sp_rg;
    any = 0;
    for (int i = 0; i < NR; i++) any |= m_en[i];
    ok = !any || (covered(s, st) && covered(e, st));
    af = (sd_rg && !sd) || (ed_rg && !ed) || (sp_rg && !sp) || (ep_rg && !ep) ||
         (sd && ep) || (sp && ed) || (sp_rg && (len != 4 || s % 4 != 0)) ||
         (!sd_rg && !sp_rg && !ok);
    mis = ((s >> 28) != (e >> 28) || (se && s % len != 0)) && ext;
    if (dma) begin af = 0; mis = 0; end
    return {in_d, in_p, ext, se, af, mis};
  endfunction

  // One clock: compare registered state to the model, then predict this edge
  task automatic step();
    rsp_t r;
    bit acc, flt;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
    chk("fault_pend", 32'(fault_pend), 32'(m_pend));
    chk("fault_addr", fault_addr, m_faddr);
    chk("fault_type", 32'(fault_type), 32'(m_ftype));
    chk("fault_store", 32'(fault_store), 32'(m_fstore));
    chk("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
    if (rst) begin
      model_reset();
    end else begin
      acc = req_valid && (!m_valid || rsp_ready);
      flt = 0;
      if (acc) begin
        r = ref_model(req_addr, req_size, req_store, req_dma, mrac);
        exp_q.push_back(r);
        flt = r[1] | r[0];
      end
      if (acc && flt) begin
        if (m_cnt < 255) m_cnt++;
        if (!m_pend || fault_clr) begin
          m_pend = 1; m_faddr = req_addr; m_ftype = {r[0], r[1]}; m_fstore = req_store;
        end
      end else if (fault_clr) begin
        m_pend = 0;
      end
      m_valid = acc ? 1'b1 : (rsp_ready ? 1'b0 : m_valid);
      if (cfg_we) begin
        m_base[cfg_idx] = cfg_base; m_mask[cfg_idx] = cfg_mask;
        m_en[cfg_idx] = cfg_en; m_rd[cfg_idx] = cfg_rd; m_wr[cfg_idx] = cfg_wr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(logic [31:0] a, logic [1:0] sz, logic st, logic dma);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_store = st; req_dma = dma;
  endtask

  // Monitor: pops on every output handshake and checks hold stability under back-pressure
  initial begin
    rsp_t act, prev, e;
    bit prev_hold = 0;
    forever begin
      @(negedge clk);
      act = {rsp_in_dccm, rsp_in_pic, rsp_external, rsp_sideeffects,
             rsp_access_fault, rsp_misaligned};
      if (prev_hold) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rsp", 32'(act), 32'(prev));
      end
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_fields", 32'(act), 32'(e));
        end
      end
      prev_hold = rsp_valid && !rsp_ready && !rst;
      prev = act;
    end
  end

  initial begin
    logic [31:0] a;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    req(32'hF004_0010, 2'd2, 0, 0); step();
    req(32'hF004_FFFF, 2'd1, 0, 0); step();
    // Table write and a store in the same cycle: the store sees the empty table
    cfg_we = 1; cfg_idx = 0; cfg_base = 32'h2000_0000; cfg_mask = 32'h0FFF_FFFF;
    cfg_en = 1; cfg_rd = 1; cfg_wr = 0;
    req(32'h2000_0100, 2'd2, 1, 0); step();
    cfg_we = 0;
    req(32'h2000_0100, 2'd2, 1, 0); step();
    req(32'h2000_0100, 2'd2, 0, 0); step();
    mrac = 32'h0000_0020;
    req(32'h2000_0002, 2'd2, 0, 0); step();
    req(32'h2000_0002, 2'd2, 0, 1); step();
    rsp_ready = 0;
    req(32'hF00C_0004, 2'd2, 0, 0); step();
    req(32'hF004_0020, 2'd0, 1, 0);
    repeat (3) step();
    rsp_ready = 1; step();
    req_valid = 0; step();
    fault_clr = 1; req(32'hF00C_0001, 2'd2, 0, 0); step();
    fault_clr = 0; req_valid = 0;
    chk("clr_capture_addr", fault_addr, 32'hF00C_0001);
    chk("clr_capture_pend", 32'(fault_pend), 32'd1);
    fault_clr = 1; step();
    fault_clr = 0; step();
    for (int i = 0; i < 300; i++) begin
      req(32'hF004_FFFF, 2'd1, 0, 0); step();
    end
    chk("cnt_saturated", 32'(fault_cnt), 32'd255);
    req(32'hFFFF_FFFF, 2'd2, 0, 0); step();
    // Reset while a result is held: it is dropped and the table empties
    rsp_ready = 0; req(32'h2000_0100, 2'd2, 1, 0); step();
    req_valid = 0; rst = 1; step();
    rst = 0; rsp_ready = 1; step();
    req(32'h2000_0100, 2'd2, 1, 0); step();

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: a = 32'hF004_0000 + $urandom_range(0, 16);
        1: a = 32'hF004_FFF0 + $urandom_range(0, 31);
        2: a = 32'hF00C_0000 + $urandom_range(0, 16);
        3: a = 32'hF00C_7FF0 + $urandom_range(0, 31);
        4: a = 32'h2000_0000 | ($urandom & 32'h0000_FFFF);
        5: a = {4'($urandom_range(0, 15)), 28'hFFF_FFFC} + $urandom_range(0, 3);
        6: a = {4'hF, 28'($urandom)};
        default: a = $urandom;
      endcase
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr = a;
      req_size = 2'($urandom_range(0, 3));
      req_store = 1'($urandom);
      req_dma = ($urandom_range(0, 9) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      fault_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) mrac = $urandom;
      cfg_we = ($urandom_range(0, 19) == 0);
      cfg_idx = 3'($urandom);
      cfg_base = {4'($urandom_range(0, 15)), 28'h0};
      case ($urandom_range(0, 2))
        0: cfg_mask = 32'h0FFF_FFFF;
        1: cfg_mask = 32'h0000_FFFF;
        default: cfg_mask = 32'hFFFF_FFFF;
      endcase
      cfg_en = ($urandom_range(0, 3) != 0);
      cfg_rd = 1'($urandom);
      cfg_wr = 1'($urandom);
      step();
    end

    req_valid = 0; cfg_we = 0; fault_clr = 0; rsp_ready = 1;
    repeat (3) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
